// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply (shift-add) and restoring divide sequencer.
// Optional build macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish without iterating.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  input  logic [2:0]      OP,
  input  logic [XLEN-1:0] OPERAND1,
  input  logic [XLEN-1:0] OPERAND2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam int unsigned      CW        = $clog2(XLEN);
  localparam logic [CW-1:0]    LAST_ITER = CW'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic              r_sign1, r_sign2, r_dz, r_ovf;
  logic [XLEN-1:0]   r_mag1, r_mag2, r_hi, r_lo;
  logic              r_busy, r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_accept, w_last, w_sgn1_en, w_sgn2_en, w_sign1, w_sign2;
  logic              w_dz, w_ovf, w_early;
  logic [XLEN-1:0]   w_mag1, w_mag2, w_spec_in;

  // Request decode: signedness, magnitudes and special cases seen at the accepting edge
  always_comb begin
    w_accept  = START & ~FLUSH & ((r_state == S_IDLE) | (r_state == S_DONE));
    w_last    = (r_state == S_CALC) & (r_cnt == LAST_ITER);
    w_sgn1_en = OP[2] ? ~OP[0] : ((OP[1:0] == 2'b01) | (OP[1:0] == 2'b10));
    w_sgn2_en = OP[2] ? ~OP[0] : (OP[1:0] == 2'b01);
    w_sign1   = w_sgn1_en & OPERAND1[XLEN-1];
    w_sign2   = w_sgn2_en & OPERAND2[XLEN-1];
    w_mag1    = w_sign1 ? -OPERAND1 : OPERAND1;
    w_mag2    = w_sign2 ? -OPERAND2 : OPERAND2;
    w_dz      = OP[2] & (OPERAND2 == '0);
    w_ovf     = OP[2] & ~OP[0] & (OPERAND1 == MIN_NEG) & (OPERAND2 == '1);
    w_early   = EARLY_OUT & (w_dz | w_ovf);
    w_spec_in = w_dz ? (OP[1] ? OPERAND1 : '1) : (OP[1] ? '0 : MIN_NEG);
  end

  logic [XLEN:0]     w_madd, w_shift, w_trial;
  logic              w_borrow, w_neg;
  logic [XLEN-1:0]   w_hi_nxt, w_lo_nxt, w_quo, w_rem, w_rs1, w_final;
  logic [2*XLEN-1:0] w_prod_raw, w_prod;

  // One iteration step plus the sign fix / result select used on the final edge
  always_comb begin
    w_madd   = {1'b0, r_hi} + {1'b0, ({XLEN{r_lo[0]}} & r_mag1)};
    w_shift  = {r_hi, r_lo[XLEN-1]};
    w_trial  = w_shift - {1'b0, r_mag2};
    w_borrow = w_trial[XLEN];
    if (r_op[2]) begin
      w_hi_nxt = w_borrow ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
      w_lo_nxt = {r_lo[XLEN-2:0], ~w_borrow};
    end else begin
      w_hi_nxt = w_madd[XLEN:1];
      w_lo_nxt = {w_madd[0], r_lo[XLEN-1:1]};
    end
    w_neg      = r_sign1 ^ r_sign2;
    w_prod_raw = {w_hi_nxt, w_lo_nxt};
    w_prod     = w_neg ? -w_prod_raw : w_prod_raw;
    w_quo      = w_neg ? -w_lo_nxt : w_lo_nxt;
    w_rem      = r_sign1 ? -w_hi_nxt : w_hi_nxt;
    w_rs1      = r_sign1 ? -r_mag1 : r_mag1;
    case (r_op)
      3'b000:                 w_final = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final = w_quo;
      default:                w_final = w_rem;
    endcase
    if (r_dz) begin
      w_final = r_op[1] ? w_rs1 : '1;
    end else if (r_ovf) begin
      w_final = r_op[1] ? '0 : MIN_NEG;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_early ? S_DONE : S_CALC;
      S_CALC: begin
        if (FLUSH)       w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: w_state_nxt = w_accept ? (w_early ? S_DONE : S_CALC) : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture and iterating datapath; r_hi/r_lo hold {acc_hi, multiplier} or {remainder, quotient}
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_sign1 <= 1'b0;
      r_sign2 <= 1'b0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
      r_mag1  <= '0;
      r_mag2  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_op    <= OP;
      r_sign1 <= w_sign1;
      r_sign2 <= w_sign2;
      r_dz    <= w_dz;
      r_ovf   <= w_ovf;
      r_mag1  <= w_mag1;
      r_mag2  <= w_mag2;
      r_hi    <= '0;
      r_lo    <= OP[2] ? w_mag1 : w_mag2;
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + CW'(1);
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_busy <= (w_state_nxt == S_CALC);
      r_done <= (w_state_nxt == S_DONE);
      if (w_accept && w_early) r_result <= w_spec_in;
      else if (w_last && !FLUSH) r_result <= w_final;
    end
  end

  assign BUSY   = r_busy;
  assign DONE   = r_done;
  assign RESULT = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and randomized checks of muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] op1, op2;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_sequencer #(.XLEN(32)) u_dut (
    .CLK(clk), .RESET_N(rst_n), .START(start), .OP(op), .OPERAND1(op1), .OPERAND2(op2),
    .FLUSH(flush), .BUSY(busy), .DONE(done), .RESULT(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // RV32M semantics with plain wide arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub_s, p;
    logic [63:0]        up;
    logic signed [31:0] a32, b32;
    logic               ovf;
    sa   = {{32{a[31]}}, a};
    sb   = {{32{b[31]}}, b};
    ub_s = {32'h0, b};
    a32  = a;
    b32  = b;
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub_s; return p[63:32]; end
      3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(a32 / b32));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'h0 : 32'(a32 % b32));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    return (EARLY && special) ? 1 : 33;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called at posedge+1; returns in the DONE cycle (or after the cycle budget expires)
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_n);
    start = 1'b1; op = f3; op1 = a; op2 = b;
    busy_n = 0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  localparam int NDIR = 14;
  logic [2:0]  d_op  [NDIR] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                 3'd4, 3'd7, 3'd4, 3'd6, 3'd5, 3'd6};
  logic [31:0] d_a   [NDIR] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFF9};
  logic [31:0] d_b   [NDIR] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'd2, 32'd2, 32'd7, 32'd7,
                                 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
  logic [31:0] d_exp [NDIR] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9};

  initial begin
    logic [31:0] got, prev, a, b;
    logic [2:0]  f3;
    int          lat, bz, el, seen;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; op1 = '0; op2 = '0;
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, issued back-to-back from each DONE cycle
    for (int i = 0; i < NDIR; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], got, lat, bz);
      el = exp_lat(d_op[i], d_a[i], d_b[i]);
      chk($sformatf("dir%0d_result", i), got, d_exp[i]);
      chk($sformatf("dir%0d_latency", i), 32'(lat), 32'(el));
      chk($sformatf("dir%0d_busy_cycles", i), 32'(bz), 32'(el - 1));
    end

    // Flush on the 10th CALC cycle
    prev = result;
    start = 1'b1; op = 3'd0; op1 = 32'd3; op2 = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy_after", 32'(busy), 32'd0);
    chk("flush_no_done", 32'(done), 32'd0);
    chk("flush_result_kept", result, prev);
    run_op(3'd0, 32'd6, 32'd7, got, lat, bz);
    chk("after_flush_result", got, 32'd42);
    chk("after_flush_latency", 32'(lat), 32'd33);

    // Start and flush together: request dropped
    start = 1'b1; flush = 1'b1; op = 3'd3; op1 = 32'd9; op2 = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("start_flush_busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (40) begin
      if (done || busy) seen++;
      @(posedge clk); #1;
    end
    chk("start_flush_ignored", 32'(seen), 32'd0);

    // Asynchronous reset mid-CALC
    start = 1'b1; op = 3'd5; op1 = 32'd1000; op2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_result", result, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(3'd0, 32'd3, 32'd4, got, lat, bz);
    chk("post_reset_mul", got, 32'd12);
    chk("post_reset_latency", 32'(lat), 32'd33);

    // Randomized operations against the reference model
    for (int i = 0; i < 300; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = rand_operand();
      b  = rand_operand();
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      run_op(f3, a, b, got, lat, bz);
      el = exp_lat(f3, a, b);
      chk($sformatf("rnd%0d_op%0d_%08h_%08h", i, f3, a, b), got, ref_model(f3, a, b));
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(el));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the RV32M multiply/divide operations that the single-cycle ALU does not implement. It accepts one operation from the EX stage, runs a 32-iteration shift-add multiply or restoring divide over an internal datapath, and returns a 32-bit result. While it runs it drives `BUSY`, which the pipeline control uses to stall EX.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `START` in 1: request valid; sampled only in IDLE or DONE.
- `OP` in 3: RV32M funct3. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `OPERAND1` in 32: rs1 value; dividend or multiplicand.
- `OPERAND2` in 32: rs2 value; divisor or multiplier.
- `FLUSH` in 1: abort the operation in flight (branch or exception flush).
- `BUSY` out 1: high while in CALC; stall request to the pipeline.
- `DONE` out 1: one-cycle pulse; `RESULT` is valid in that cycle.
- `RESULT` out 32: final result, held until the next completion.

## Operation
- States: IDLE, CALC, DONE.
  - IDLE: `START` & !`FLUSH` → CALC.
  - CALC: iteration counter 0..31; after iteration 31 → DONE.
  - DONE: `START` & !`FLUSH` → CALC (back-to-back); otherwise → IDLE.
- Capture (on the accepting edge): latch `OP`, both operand signs, and operand magnitudes.
  - Operands are signed for MULH/DIV/REM, rs1 only for MULHSU, and neither for MUL/MULHU/DIVU/REMU.
  - Magnitude = two's-complement negate when the operand is signed and negative. 0x80000000 stays 0x80000000 as an unsigned magnitude.
- Multiply datapath: 64-bit accumulator; one shift-add per CALC cycle, LSB-first on the multiplier.
- Divide datapath: restoring algorithm; 32-bit remainder register plus 33-bit trial subtract; one quotient bit per CALC cycle, MSB-first.
- Sign fix (combinational, on the final CALC edge, before `RESULT` is registered):
  - Product: negate the 64-bit product when the effective signs differ.
  - Quotient: negate when the dividend and divisor signs differ.
  - Remainder: takes the dividend's sign.
- Result selection:
  - MUL → product[31:0].
  - MULH/MULHSU/MULHU → product[63:32].
  - DIV/DIVU → quotient.
  - REM/REMU → remainder.
- Special cases (required results in every build):
  - Divide by zero: quotient = 0xFFFFFFFF for both DIV and DIVU; remainder = rs1.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- `START` while in CALC is ignored; the requester holds it until `BUSY` drops.
- `FLUSH` in CALC or DONE → IDLE on the next edge. No `DONE` pulse is issued and `RESULT` is unchanged. `FLUSH` with `START` in the same cycle: the flush wins and the request is not accepted.
- `RESET_N` low at any time: immediately IDLE, counter 0, `BUSY` 0, `DONE` 0, `RESULT` 0x00000000.

## Timing
- Accepting edge E0 → CALC at E0..E31 (`BUSY` high for 32 cycles). `RESULT` is registered at E32; `DONE` and valid `RESULT` appear in the cycle after E32.
- Latency is 33 cycles from the accepting edge to `DONE`, independent of operand values (unless early-out applies; see Configuration).
- `BUSY` is low in the DONE cycle. A new `START` in that cycle is accepted, giving a 33-cycle issue interval.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined: divide by zero and signed overflow skip CALC. The accepting edge goes straight to DONE with the special-case result registered, so `DONE` appears 1 cycle after acceptance and `BUSY` never rises.
- Undefined: these cases run the full 32 iterations and force the special-case result at E32, so latency stays 33 cycles.
- Multiply latency and all other results are identical in both builds.

## Test plan
- MUL 7 × 0xFFFFFFFD → `RESULT` 0xFFFFFFEB; `DONE` exactly 33 cycles after `START`; `BUSY` high for exactly 32 cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM of the same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFFFFFF and REMU 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0. `DONE` after 1 cycle with `MULDIV_EARLY_OUT_EN`, after 33 without.
- `FLUSH` on the 10th CALC cycle → `BUSY` low next cycle, no `DONE`, `RESULT` keeps its prior value. A `START` issued the following cycle completes normally. A `START` issued in the `DONE` cycle is accepted back-to-back.
- `RESET_N` pulsed low mid-CALC → `BUSY`, `DONE`, and `RESULT` go to 0 immediately. After release, a new MUL 3 × 4 → 12.
